// File: rtl/ex_stage_pipe.sv
// Two-stage pipelined execute unit with valid/ready handshaking.
// Stage 1 registers pre-processed operands; stage 2 runs the ALU and
// registers the result, status flags and store request.
module ex_stage_pipe #(
    parameter int REG_WD = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_ex,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_WD-1:0] src1,
    input  logic [REG_WD-1:0] src2,
    input  logic [REG_WD-1:0] imm,
    input  logic [6:0]        control_in,
    input  logic [REG_WD-1:0] mem_data_read_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_WD-1:0] aluout,
    output logic [REG_WD-1:0] mem_data_write_out,
    output logic              mem_write_en,
    output logic              carry,
    output logic              zero,
    output logic              overflow
);
    localparam int SH_WD = $clog2(REG_WD);

    localparam logic [2:0] OPS_SHIFT = 3'b000;
    localparam logic [2:0] OPS_ARITH = 3'b001;
    localparam logic [2:0] OPS_LOAD  = 3'b100;
    localparam logic [2:0] OPS_STORE = 3'b101;

    // Stage 1 registers
    logic              s1_valid_q;
    logic [REG_WD-1:0] s1_a_q, s1_b_q, s1_st_q, s1_ld_q, s1_addr_q;
    logic [2:0]        s1_opsel_q, s1_op_q;

    // Stage 2 registers
    logic              s2_valid_q;
    logic [REG_WD-1:0] res_q, mdw_q;
    logic              mwe_q, c_q, z_q, v_q;

    logic              s1_adv_s, s2_adv_s;
    logic [REG_WD-1:0] res_d;
    logic              c_d, v_d, z_d;

    logic [REG_WD:0]   sum_s;
    logic [REG_WD-1:0] diff_s;
    logic [SH_WD-1:0]  amt_s, sll_idx_s, srl_idx_s;
    logic [SH_WD:0]    rot_s;
    logic              msb_a_s, msb_b_s;

    assign s2_adv_s = enable_ex & (~s2_valid_q | out_ready);
    assign s1_adv_s = enable_ex & (~s1_valid_q | s2_adv_s);
    assign in_ready = reset & s1_adv_s;

    assign sum_s     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_s    = s1_a_q - s1_b_q;
    assign amt_s     = s1_b_q[SH_WD-1:0];
    // REG_WD is a power of two, so 0 - amt wraps to REG_WD - amt
    assign sll_idx_s = {SH_WD{1'b0}} - amt_s;
    assign srl_idx_s = amt_s - {{(SH_WD-1){1'b0}}, 1'b1};
    assign rot_s     = (SH_WD+1)'(REG_WD) - {1'b0, amt_s};
    assign msb_a_s   = s1_a_q[REG_WD-1];
    assign msb_b_s   = s1_b_q[REG_WD-1];

    // ALU: result and flags from the stage-1 registers
    always_comb begin
        res_d = {REG_WD{1'b0}};
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (s1_opsel_q)
            OPS_ARITH: begin
                case (s1_op_q)
                    3'b000: begin
                        res_d = sum_s[REG_WD-1:0];
                        c_d   = sum_s[REG_WD];
                        v_d   = ~(msb_a_s ^ msb_b_s) & (sum_s[REG_WD-1] ^ msb_a_s);
                    end
                    3'b001: begin
                        res_d = diff_s;
                        c_d   = (s1_a_q < s1_b_q);
                        v_d   = (msb_a_s ^ msb_b_s) & (diff_s[REG_WD-1] ^ msb_a_s);
                    end
                    3'b010:  res_d = s1_a_q & s1_b_q;
                    3'b011:  res_d = s1_a_q | s1_b_q;
                    3'b100:  res_d = s1_a_q ^ s1_b_q;
                    3'b101:  res_d = ~s1_a_q;
                    3'b110:  res_d = s1_b_q;
                    3'b111:  res_d = {{(REG_WD-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
                    default: res_d = {REG_WD{1'b0}};
                endcase
            end
            OPS_SHIFT: begin
                case (s1_op_q)
                    3'b000: begin
                        res_d = s1_a_q << amt_s;
                        if (amt_s != {SH_WD{1'b0}}) c_d = s1_a_q[sll_idx_s];
                        else                        c_d = 1'b0;
                    end
                    3'b001: begin
                        res_d = s1_a_q >> amt_s;
                        if (amt_s != {SH_WD{1'b0}}) c_d = s1_a_q[srl_idx_s];
                        else                        c_d = 1'b0;
                    end
                    3'b010: begin
                        res_d = $signed(s1_a_q) >>> amt_s;
                        if (amt_s != {SH_WD{1'b0}}) c_d = s1_a_q[srl_idx_s];
                        else                        c_d = 1'b0;
                    end
                    3'b011:  res_d = (s1_a_q << amt_s) | (s1_a_q >> rot_s);
                    default: res_d = s1_a_q;
                endcase
            end
            OPS_LOAD:  res_d = s1_ld_q;
            OPS_STORE: res_d = s1_addr_q;
            default:   res_d = {REG_WD{1'b0}};
        endcase
        z_d = (res_d == {REG_WD{1'b0}});
    end

    // Stage 1: operand pre-processing register
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {REG_WD{1'b0}};
            s1_b_q     <= {REG_WD{1'b0}};
            s1_st_q    <= {REG_WD{1'b0}};
            s1_ld_q    <= {REG_WD{1'b0}};
            s1_addr_q  <= {REG_WD{1'b0}};
            s1_opsel_q <= 3'b000;
            s1_op_q    <= 3'b000;
        end else if (s1_adv_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q     <= src1;
                s1_b_q     <= control_in[6] ? imm : src2;
                s1_st_q    <= src2;
                s1_ld_q    <= mem_data_read_in;
                s1_addr_q  <= src1 + imm;
                s1_opsel_q <= control_in[5:3];
                s1_op_q    <= control_in[2:0];
            end
        end
    end

    // Stage 2: result, flag and store-request register
    always_ff @(posedge clock) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            res_q      <= {REG_WD{1'b0}};
            mdw_q      <= {REG_WD{1'b0}};
            mwe_q      <= 1'b0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_q <= s1_valid_q;
            mwe_q      <= s1_valid_q & (s1_opsel_q == OPS_STORE);
            if (s1_valid_q) begin
                res_q <= res_d;
                mdw_q <= s1_st_q;
                c_q   <= c_d;
                z_q   <= z_d;
                v_q   <= v_d;
            end
        end
    end

    assign out_valid          = s2_valid_q;
    assign aluout             = res_q;
    assign mem_data_write_out = mdw_q;
    assign mem_write_en       = mwe_q;
    assign carry              = c_q;
    assign zero               = z_q;
    assign overflow           = v_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed, table-driven bench for ex_stage_pipe (REG_WD = 32).
module tb_ex_stage_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_ex = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src1 = 32'h0, src2 = 32'h0, imm = 32'h0, mem_data_read_in = 32'h0;
    logic [6:0]  control_in = 7'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] aluout, mem_data_write_out;
    logic        mem_write_en, carry, zero, overflow;

    int n_cmp  = 0;
    int n_miss = 0;

    ex_stage_pipe #(.REG_WD(32)) dut (
        .clock(clock), .reset(reset), .enable_ex(enable_ex),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
        .mem_data_read_in(mem_data_read_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .mem_data_write_out(mem_data_write_out),
        .mem_write_en(mem_write_en), .carry(carry), .zero(zero), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        isel;
        logic [2:0]  opsel;
        logic [2:0]  op;
        logic [31:0] s1, s2, im, ld;
        logic [31:0] res;
        logic        c, z, v, we;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int k);
        int lat;
        @(posedge clock); #1;
        src1 = vecs[k].s1; src2 = vecs[k].s2; imm = vecs[k].im;
        mem_data_read_in = vecs[k].ld;
        control_in = {vecs[k].isel, vecs[k].opsel, vecs[k].op};
        in_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", k), {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 6) begin
            @(posedge clock); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", k), lat, 32'd2);
        chk($sformatf("v%0d_aluout", k), aluout, vecs[k].res);
        chk($sformatf("v%0d_flags_czvw", k), {28'b0, carry, zero, overflow, mem_write_en},
            {28'b0, vecs[k].c, vecs[k].z, vecs[k].v, vecs[k].we});
        if (vecs[k].we) chk($sformatf("v%0d_wdata", k), mem_data_write_out, vecs[k].s2);
    endtask

    initial begin
        int sent, got, nwe, lat;
        logic [31:0] held;
        logic hold_p;

        //          isel  opsel   op      src1          src2          imm           ld            result        c     z     v     we
        vecs[0]  = '{1'b0, 3'b001, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'b001, 3'b001, 32'h00000005, 32'h00000007, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 3'b001, 32'h00000009, 32'h00000009, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 3'b010, 32'h80000010, 32'h0,        32'h4,        32'h0,        32'hF8000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'b000, 3'b000, 32'hF0000000, 32'h0,        32'h4,        32'h0,        32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b001, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b001, 3'b011, 32'h0000FF00, 32'h00FF0000, 32'h0,        32'h0,        32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        32'h0,        32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 3'b101, 32'h00000000, 32'h12345678, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b001, 3'b110, 32'h11111111, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'b001, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'b001, 3'b111, 32'h00000005, 32'hFFFFFFFD, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'b000, 3'b001, 32'h80000001, 32'h00000001, 32'h0,        32'h0,        32'h40000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 3'b000, 3'b011, 32'h80000001, 32'h00000004, 32'h0,        32'h0,        32'h00000018, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 3'b100, 32'h12345678, 32'h00000003, 32'h0,        32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 3'b100, 3'b000, 32'h00000004, 32'h00000004, 32'h0,        32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 3'b101, 3'b000, 32'h00000100, 32'h0000DEAD, 32'h8,        32'h0,        32'h00000108, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 3'b111, 3'b000, 32'h00000005, 32'h00000005, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 3'b001, 3'b001, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 3'b000, 3'b000, 32'h00000005, 32'h00000000, 32'h0,        32'h0,        32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held low three cycles with a valid input pending
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_aluout", aluout, 32'h0);
        chk("rst_flags_czvw", {28'b0, carry, zero, overflow, mem_write_en}, 32'h0);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        for (int k = 0; k < 21; k++) apply_vec(k);

        // Back-pressure: four ADDs, out_ready low for cycles 3..6
        sent = 0; got = 0; hold_p = 1'b0; held = 32'h0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clock); #1;
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (sent < 4);
            src1 = 32'h00001000 + 32'(sent);
            src2 = 32'h00000100;
            control_in = {1'b0, 3'b001, 3'b000};
            #1;
            if (hold_p) begin
                chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
                chk($sformatf("bp_hold_data_c%0d", c), aluout, held);
            end
            if (c <= 7)
                chk($sformatf("bp_in_ready_c%0d", c), {31'b0, in_ready}, (c < 3 || c == 7) ? 32'd1 : 32'd0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_result_%0d", got), aluout, 32'h00001100 + 32'(got));
                got++;
            end
            hold_p = out_valid && !out_ready;
            held = aluout;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_delivered", got, 32'd4);

        // STORE with enable_ex dropped for two cycles mid-flight
        @(posedge clock); #1;
        src1 = 32'h100; imm = 32'h8; src2 = 32'hDEAD;
        control_in = {1'b1, 3'b101, 3'b000};
        in_valid = 1'b1;
        #1;
        chk("st_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        enable_ex = 1'b0;
        #1;
        chk("st_stall_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        enable_ex = 1'b1;
        chk("st_stall_out_valid", {31'b0, out_valid}, 32'd0);
        lat = 3;
        while (!out_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("st_latency", lat, 32'd4);
        chk("st_aluout", aluout, 32'h108);
        chk("st_wdata", mem_data_write_out, 32'hDEAD);
        chk("st_we", {31'b0, mem_write_en}, 32'd1);
        nwe = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            if (mem_write_en) nwe++;
        end
        chk("st_we_pulses", nwe, 32'd1);

        // Reset mid-flight discards the in-flight entry
        @(posedge clock); #1;
        src1 = 32'h5; src2 = 32'h6; control_in = {1'b0, 3'b001, 3'b000};
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("midrst_out_valid_%0d", c), {31'b0, out_valid}, 32'd0);
            @(posedge clock); #1;
        end
        chk("midrst_aluout", aluout, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
